// File: rtl/reg_top_apb_block.sv
// APB slave holding five 32-bit single-field registers (r, rw, rw1, w, w1),
// each with a hardware write port that loses to a same-cycle software write.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | no transfer; a setup phase (PSEL & !PENABLE) moves to S_ACCESS
// S_ACCESS | first enable cycle, PREADY=0; write commits at the closing edge
// S_ACK    | PREADY=1 with registered PRDATA/PSLVERR; returns to S_IDLE
module reg_top_apb_block #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PREADY,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PSLVERR,
    input  logic                  clear,
    output logic                  interrupt,
    output logic                  global_sync_reset_out,
    input  logic [DATA_WIDTH-1:0] REG1_SW_RO__FIELD_0__next_value,
    input  logic                  REG1_SW_RO__FIELD_0__pulse,
    output logic [DATA_WIDTH-1:0] REG1_SW_RO__FIELD_0__curr_value,
    input  logic [DATA_WIDTH-1:0] REG2_SW_RW__FIELD_0__next_value,
    input  logic                  REG2_SW_RW__FIELD_0__pulse,
    output logic [DATA_WIDTH-1:0] REG2_SW_RW__FIELD_0__curr_value,
    input  logic [DATA_WIDTH-1:0] REG3_SW_RW1__FIELD_0__next_value,
    input  logic                  REG3_SW_RW1__FIELD_0__pulse,
    output logic [DATA_WIDTH-1:0] REG3_SW_RW1__FIELD_0__curr_value,
    input  logic [DATA_WIDTH-1:0] REG4_SW_WO__FIELD_0__next_value,
    input  logic                  REG4_SW_WO__FIELD_0__pulse,
    output logic [DATA_WIDTH-1:0] REG4_SW_WO__FIELD_0__curr_value,
    input  logic [DATA_WIDTH-1:0] REG5_SW_W1__FIELD_0__next_value,
    input  logic                  REG5_SW_W1__FIELD_0__pulse,
    output logic [DATA_WIDTH-1:0] REG5_SW_W1__FIELD_0__curr_value
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_ACK    = 2'd2
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] field    [5];
    logic [DATA_WIDTH-1:0] hw_value [5];
    logic                  hw_pulse [5];
    logic                  flag_rw1;
    logic                  flag_w1;
    logic [4:0]            sw_we;
    logic [2:0]            addr_idx;
    logic                  addr_hit;
    logic                  commit;
    logic [DATA_WIDTH-1:0] rdata;

    // No interrupt sources exist, so clear is intentionally left unconnected.
    logic unused_clear;
    assign unused_clear          = clear;
    assign interrupt             = 1'b0;
    assign global_sync_reset_out = 1'b0;

    assign hw_value[0] = REG1_SW_RO__FIELD_0__next_value;
    assign hw_value[1] = REG2_SW_RW__FIELD_0__next_value;
    assign hw_value[2] = REG3_SW_RW1__FIELD_0__next_value;
    assign hw_value[3] = REG4_SW_WO__FIELD_0__next_value;
    assign hw_value[4] = REG5_SW_W1__FIELD_0__next_value;
    assign hw_pulse[0] = REG1_SW_RO__FIELD_0__pulse;
    assign hw_pulse[1] = REG2_SW_RW__FIELD_0__pulse;
    assign hw_pulse[2] = REG3_SW_RW1__FIELD_0__pulse;
    assign hw_pulse[3] = REG4_SW_WO__FIELD_0__pulse;
    assign hw_pulse[4] = REG5_SW_W1__FIELD_0__pulse;

    assign REG1_SW_RO__FIELD_0__curr_value  = field[0];
    assign REG2_SW_RW__FIELD_0__curr_value  = field[1];
    assign REG3_SW_RW1__FIELD_0__curr_value = field[2];
    assign REG4_SW_WO__FIELD_0__curr_value  = field[3];
    assign REG5_SW_W1__FIELD_0__curr_value  = field[4];

    assign addr_idx = PADDR[4:2];
    assign addr_hit = (PADDR[ADDR_WIDTH-1:5] == '0) && (PADDR[1:0] == 2'b00)
                      && (addr_idx <= 3'd4);
    assign commit   = (state == S_ACCESS) && PSEL && PENABLE;

    always_comb begin
        sw_we = '0;
        if (commit && PWRITE && addr_hit) begin
            case (addr_idx)
                3'd1:    sw_we[1] = 1'b1;
                3'd2:    sw_we[2] = !flag_rw1;
                3'd3:    sw_we[3] = 1'b1;
                3'd4:    sw_we[4] = !flag_w1;
                default: sw_we    = '0;
            endcase
        end
    end

    // Write-only registers read back as zero.
    always_comb begin
        rdata = '0;
        if (addr_hit) begin
            case (addr_idx)
                3'd0:    rdata = field[0];
                3'd1:    rdata = field[1];
                3'd2:    rdata = field[2];
                default: rdata = '0;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < 5; i++) field[i] <= '0;
            flag_rw1 <= 1'b0;
            flag_w1  <= 1'b0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (sw_we[i])         field[i] <= PWDATA;
                else if (hw_pulse[i]) field[i] <= hw_value[i];
            end
            if (sw_we[2]) flag_rw1 <= 1'b1;
            if (sw_we[4]) flag_w1  <= 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state   <= S_IDLE;
            PREADY  <= 1'b0;
            PRDATA  <= '0;
            PSLVERR <= 1'b0;
        end else begin
            PREADY  <= 1'b0;
            PRDATA  <= '0;
            PSLVERR <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (PSEL && !PENABLE) state <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (commit) begin
                        state   <= S_ACK;
                        PREADY  <= 1'b1;
                        PSLVERR <= !addr_hit;
                        if (!PWRITE) PRDATA <= rdata;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_ACK:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_top_apb_block.sv
// Bench for reg_top_apb_block: directed plan steps plus randomized traffic
// checked against a register-semantics reference model.
module tb_reg_top_apb_block;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        PSEL, PENABLE, PWRITE;
    logic [63:0] PADDR;
    logic [31:0] PWDATA;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;
    logic        clear;
    logic        interrupt, global_sync_reset_out;
    logic [31:0] nv [5];
    logic        pl [5];
    logic [31:0] cv [5];

    int errors = 0;
    int checks = 0;

    logic [31:0] mfield [5];
    bit          mflag3, mflag5;

    always #5 PCLK = ~PCLK;

    reg_top_apb_block dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(PREADY),
        .PRDATA(PRDATA), .PSLVERR(PSLVERR), .clear(clear), .interrupt(interrupt),
        .global_sync_reset_out(global_sync_reset_out),
        .REG1_SW_RO__FIELD_0__next_value(nv[0]),  .REG1_SW_RO__FIELD_0__pulse(pl[0]),
        .REG1_SW_RO__FIELD_0__curr_value(cv[0]),
        .REG2_SW_RW__FIELD_0__next_value(nv[1]),  .REG2_SW_RW__FIELD_0__pulse(pl[1]),
        .REG2_SW_RW__FIELD_0__curr_value(cv[1]),
        .REG3_SW_RW1__FIELD_0__next_value(nv[2]), .REG3_SW_RW1__FIELD_0__pulse(pl[2]),
        .REG3_SW_RW1__FIELD_0__curr_value(cv[2]),
        .REG4_SW_WO__FIELD_0__next_value(nv[3]),  .REG4_SW_WO__FIELD_0__pulse(pl[3]),
        .REG4_SW_WO__FIELD_0__curr_value(cv[3]),
        .REG5_SW_W1__FIELD_0__next_value(nv[4]),  .REG5_SW_W1__FIELD_0__pulse(pl[4]),
        .REG5_SW_W1__FIELD_0__curr_value(cv[4])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit mapped(input logic [63:0] a);
        return (a < 64'h14) && (a[1:0] == 2'b00);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 5; i++) mfield[i] = '0;
        mflag3 = 1'b0;
        mflag5 = 1'b0;
    endfunction

    function automatic void model_sw_write(input logic [63:0] a, input logic [31:0] d);
        if (!mapped(a)) return;
        case (a[4:2])
            3'd1: mfield[1] = d;
            3'd2: if (!mflag3) begin mfield[2] = d; mflag3 = 1'b1; end
            3'd3: mfield[3] = d;
            3'd4: if (!mflag5) begin mfield[4] = d; mflag5 = 1'b1; end
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [63:0] a);
        if (mapped(a) && a[4:2] <= 3'd2) return mfield[a[4:2]];
        return 32'h0;
    endfunction

    task automatic check_curr(input string tag);
        for (int i = 0; i < 5; i++)
            chk($sformatf("%s curr%0d", tag, i + 1), cv[i], mfield[i]);
        chk({tag, " interrupt"}, interrupt, 1'b0);
        chk({tag, " gsro"}, global_sync_reset_out, 1'b0);
    endtask

    // Ends in the ACK cycle with PSEL/PENABLE still high.
    task automatic apb_xfer(input bit wr, input logic [63:0] a, input logic [31:0] d,
                            input int hw_idx, input logic [31:0] hw_val);
        logic [31:0] exp_rd;
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
        @(negedge PCLK);
        chk("setup pready", PREADY, 1'b0);
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        if (hw_idx >= 0) begin nv[hw_idx] = hw_val; pl[hw_idx] = 1'b1; end
        @(negedge PCLK);
        chk("wait pready", PREADY, 1'b0);
        chk("wait prdata", PRDATA, 32'h0);
        exp_rd = wr ? 32'h0 : model_read(a);
        @(posedge PCLK);
        if (hw_idx >= 0) mfield[hw_idx] = hw_val;
        if (wr) model_sw_write(a, d);
        #1;
        if (hw_idx >= 0) pl[hw_idx] = 1'b0;
        @(negedge PCLK);
        chk("ack pready", PREADY, 1'b1);
        chk($sformatf("ack pslverr @%0h", a), PSLVERR, !mapped(a));
        chk($sformatf("ack prdata @%0h", a), PRDATA, exp_rd);
        check_curr("ack");
    endtask

    task automatic bus_idle();
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        @(negedge PCLK);
        chk("idle pready", PREADY, 1'b0);
        chk("idle prdata", PRDATA, 32'h0);
    endtask

    task automatic hw_write(input int i, input logic [31:0] v);
        @(posedge PCLK); #1;
        nv[i] = v; pl[i] = 1'b1;
        @(posedge PCLK);
        mfield[i] = v;
        #1 pl[i] = 1'b0;
        @(negedge PCLK);
        check_curr("hw");
    endtask

    initial begin
        logic [31:0] plan_exp [5];
        logic [63:0] atab [9];
        atab = '{64'h0, 64'h4, 64'h8, 64'hC, 64'h10, 64'h14, 64'h20, 64'h2, 64'h1_0000_0000};
        plan_exp = '{32'h0, 32'h12345678, 32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF};

        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; clear = 1'b0;
        for (int i = 0; i < 5; i++) begin nv[i] = '0; pl[i] = 1'b0; end
        model_reset();
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        chk("rst pready", PREADY, 1'b0);
        chk("rst prdata", PRDATA, 32'h0);
        chk("rst pslverr", PSLVERR, 1'b0);
        check_curr("rst");
        @(posedge PCLK); #1 PRESETn = 1'b1;

        for (int i = 0; i < 5; i++) begin
            apb_xfer(1'b1, 64'(i * 4), 32'hFFFFFFFF, -1, 32'h0); bus_idle();
            apb_xfer(1'b0, 64'(i * 4), 32'h0, -1, 32'h0);        bus_idle();
            apb_xfer(1'b1, 64'(i * 4), 32'h12345678, -1, 32'h0); bus_idle();
        end
        for (int i = 0; i < 5; i++)
            chk($sformatf("plan curr%0d", i + 1), cv[i], plan_exp[i]);

        hw_write(0, 32'hA5A5A5A5);
        chk("hw reg1", cv[0], 32'hA5A5A5A5);
        apb_xfer(1'b0, 64'h0, 32'h0, -1, 32'h0); bus_idle();

        apb_xfer(1'b1, 64'h4, 32'h11111111, 1, 32'h22222222); bus_idle();
        chk("collision reg2", cv[1], 32'h11111111);

        apb_xfer(1'b0, 64'h20, 32'h0, -1, 32'h0);         bus_idle();
        apb_xfer(1'b1, 64'h20, 32'hDEADBEEF, -1, 32'h0);  bus_idle();

        apb_xfer(1'b1, 64'h4, 32'h0BADF00D, -1, 32'h0);
        apb_xfer(1'b0, 64'h4, 32'h0, -1, 32'h0);
        bus_idle();

        // Abort: PSEL dropped during the first enable cycle.
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 64'h4; PWDATA = 32'hCAFE0001;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        repeat (2) begin
            @(negedge PCLK);
            chk("abort pready", PREADY, 1'b0);
        end
        check_curr("abort");

        repeat (60) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 2) begin
                hw_write(int'($urandom_range(0, 4)), $urandom);
            end else begin
                int h;
                h = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
                apb_xfer(1'($urandom_range(0, 1)), atab[$urandom_range(0, 8)],
                         $urandom, h, $urandom);
                if ($urandom_range(0, 1) == 1) bus_idle();
            end
            bus_idle();
        end

        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 64'h4; PWDATA = 32'h55AA55AA;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        PRESETn = 1'b0;
        model_reset();
        #1;
        chk("midrst pready", PREADY, 1'b0);
        check_curr("midrst");
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1 PRESETn = 1'b1;
        @(negedge PCLK);
        check_curr("postrst");
        apb_xfer(1'b1, 64'h8, 32'h0000BEEF, -1, 32'h0); bus_idle();
        chk("rw1 rearm", cv[2], 32'h0000BEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
